// File: rtl/dcdr_2to4.sv
// rtl/dcdr_2to4.sv - registered 2-to-4 one-hot decoder with enable and valid flag
// Optional sticky one-hot checker output onehot_err under macro DCDR_ONEHOT_CHK_EN.
module dcdr_2to4 #(
  parameter bit OUT_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic S0,
  input  logic S1,
  output logic R0,
  output logic R1,
  output logic R2,
  output logic R3,
  output logic valid
`ifdef DCDR_ONEHOT_CHK_EN
  ,
  output logic onehot_err
`endif
);

  logic [3:0] dec_d;
  logic [3:0] dec_q;
  logic       valid_d;
  logic       valid_q;
  logic [3:0] r_out;

  // Unknown or X selects fall to default so nothing decodes on garbage.
  always_comb begin
    dec_d   = 4'b0000;
    valid_d = 1'b0;
    if (en) begin
      case ({S1, S0})
        2'b00: begin dec_d = 4'b0001; valid_d = 1'b1; end
        2'b01: begin dec_d = 4'b0010; valid_d = 1'b1; end
        2'b10: begin dec_d = 4'b0100; valid_d = 1'b1; end
        2'b11: begin dec_d = 4'b1000; valid_d = 1'b1; end
        default: begin dec_d = 4'b0000; valid_d = 1'b0; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q   <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      dec_q   <= dec_d;
      valid_q <= valid_d;
    end
  end

  // Inversion sits after the register so the reset value follows polarity.
  assign r_out = OUT_ACTIVE_LOW ? ~dec_q : dec_q;
  assign {R3, R2, R1, R0} = r_out;
  assign valid = valid_q;

`ifdef DCDR_ONEHOT_CHK_EN
  logic [3:0] norm_vec;
  logic       is_onehot;
  logic       chk_bad;

  assign norm_vec  = r_out ^ {4{OUT_ACTIVE_LOW}};
  assign is_onehot = (norm_vec != 4'b0000) && ((norm_vec & (norm_vec - 4'd1)) == 4'b0000);
  assign chk_bad   = valid_q ? !is_onehot : (norm_vec != 4'b0000);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_err <= 1'b0;
    end else if (chk_bad) begin
      onehot_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dcdr_2to4.sv
// tb/tb_dcdr_2to4.sv - scoreboard bench for dcdr_2to4, active-high and active-low instances
module tb_dcdr_2to4;

  logic clk;
  logic rst_n;
  logic en;
  logic S0;
  logic S1;
  logic h_r0, h_r1, h_r2, h_r3, h_valid;
  logic l_r0, l_r1, l_r2, l_r3, l_valid;
`ifdef DCDR_ONEHOT_CHK_EN
  logic h_err;
  logic l_err;
`endif

  int checks = 0;
  int errors = 0;

  // Expected entries: {valid, R3..R0 active-high}
  logic [4:0] exp_q[$];

  dcdr_2to4 #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .en(en), .S0(S0), .S1(S1),
    .R0(h_r0), .R1(h_r1), .R2(h_r2), .R3(h_r3), .valid(h_valid)
`ifdef DCDR_ONEHOT_CHK_EN
    , .onehot_err(h_err)
`endif
  );

  dcdr_2to4 #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .S0(S0), .S1(S1),
    .R0(l_r0), .R1(l_r1), .R2(l_r2), .R3(l_r3), .valid(l_valid)
`ifdef DCDR_ONEHOT_CHK_EN
    , .onehot_err(l_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string name, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [4:0] exp);
    check_vec({tag, "_hi"}, {h_valid, h_r3, h_r2, h_r1, h_r0}, exp);
    check_vec({tag, "_lo"}, {l_valid, l_r3, l_r2, l_r1, l_r0}, {exp[4], ~exp[3:0]});
  endtask

  // Drive one cycle of stimulus between edges and queue what the following edge must produce.
  task automatic apply(input logic e, input logic [1:0] s, input logic [4:0] exp);
    @(negedge clk);
    en = e;
    {S1, S0} = s;
    exp_q.push_back(exp);
  endtask

  // Monitor: after every active edge, compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      check_outputs("decode", exp_q.pop_front());
`ifdef DCDR_ONEHOT_CHK_EN
      check_vec("onehot_err", {3'b000, h_err, l_err}, 5'b00000);
`endif
    end
  end

  typedef struct {
    logic       e;
    logic [1:0] s;
    logic [4:0] exp;
  } vec_t;

  vec_t dir_vecs[8];

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    {S1, S0} = 2'b11;
    #3;
    check_outputs("reset_no_clk", 5'b0_0000);

    @(negedge clk);
    rst_n = 1'b1;

    dir_vecs[0] = '{1'b1, 2'b00, 5'b1_0001};
    dir_vecs[1] = '{1'b1, 2'b01, 5'b1_0010};
    dir_vecs[2] = '{1'b1, 2'b10, 5'b1_0100};
    dir_vecs[3] = '{1'b1, 2'b11, 5'b1_1000};
    dir_vecs[4] = '{1'b0, 2'b10, 5'b0_0000};
    dir_vecs[5] = '{1'b1, 2'b10, 5'b1_0100};
    dir_vecs[6] = '{1'b1, 2'b00, 5'b1_0001};
    dir_vecs[7] = '{1'b1, 2'b11, 5'b1_1000};
    for (int i = 0; i < 8; i++) apply(dir_vecs[i].e, dir_vecs[i].s, dir_vecs[i].exp);

    // Outputs now 1000; drop reset between edges and expect an immediate clear.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 5'b0_0000);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 2'b01, 5'b1_0010);

    // Sweep with a fixed pseudo-random enable pattern.
    for (int i = 0; i < 16; i++) begin
      logic       e;
      logic [1:0] s;
      logic [3:0] oh;
      e  = (i % 3) != 1;
      s  = 2'(i);
      oh = 4'b0001 << s;
      apply(e, s, e ? {1'b1, oh} : 5'b0_0000);
    end
    apply(1'b0, 2'b00, 5'b0_0000);

    begin
      int budget;
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      #2;
      if (exp_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
